conv_window_feeder: RTL and testbench
=====================================

// Module: conv_window_feeder
// PURPOSE
//   Builds the 3x3xINPUT_CHANNEL int8 input windows that the 16-filter systolic conv array consumes.
//   - Input: a raster-order pixel stream, all channels of one pixel per beat.
//   - Output: one packed window per output position (stride 1, no padding), with valid/ready backpressure.
//   - Sits between the feature-map reader and the PE chain's a0 input.
// PARAMETERS
//   IMG_W          32  pixels per row (>=3)
//   IMG_H          32  rows per frame (>=3)
//   INPUT_CHANNEL  3   channels per pixel
//   DATA_W         8   bits per channel sample
//   WIN_W          9*INPUT_CHANNEL*DATA_W (216)  packed window width (derived; do not override)
// PORTS
//   clk_i        in   1                      clock, all logic rising-edge
//   rst_n        in   1                      synchronous, active-low reset
//   start_i      in   1                      1-cycle pulse: begin a frame (sampled in IDLE only)
//   pix_valid_i  in   1                      pixel beat valid
//   pix_ready_o  out  1                      pixel beat accepted when valid&ready
//   pix_data_i   in   INPUT_CHANNEL*DATA_W   channel c at [c*DATA_W +: DATA_W]
//   win_valid_o  out  1                      window valid
//   win_ready_i  in   1                      downstream accepts window when valid&ready
//   win_data_o   out  WIN_W                  packed window, layout below
//   win_row_o    out  16                     output row of window (top-left pixel row)
//   win_col_o    out  16                     output col of window (top-left pixel col)
//   busy_o       out  1                      high in ACTIVE
//   done_o       out  1                      1-cycle pulse after last window accepted
// BEHAVIOUR
//   Clock clk_i; reset rst_n synchronous, active-low. Reset: state=IDLE, all counters 0.
//   Outputs 0 under reset: pix_ready_o, win_valid_o, win_data_o, win_row_o, win_col_o, busy_o, done_o.
//   Window layout: sample (channel c, window row r 0=top, col k 0=left) at
//     win_data_o[DATA_W*(c*9 + r*3 + k) +: DATA_W].
//   FSM: IDLE --start_i--> ACTIVE --last window handshake--> DONE --(1 cycle)--> IDLE.
//     start_i outside IDLE ignored.
//   pix_ready_o = (state==ACTIVE) & ~last_pix_taken & (~win_valid_o | win_ready_i).
//   Storage: two line buffers of IMG_W pixels (rows y-1, y-2) plus 3x3 pixel shift registers.
//     Line-buffer contents need no reset.
//   Counters: pixel col x 0..IMG_W-1, row y 0..IMG_H-1; x wraps to 0 and y increments at end of row.
//   Accepting pixel (y,x) with y>=2 & x>=2 loads a window for top-left (y-2,x-2):
//     win_data_o, win_row_o=y-2, win_col_o=x-2; win_valid_o=1 on the next cycle (latency 1).
//   Pixels with y<2 or x<2 only fill buffers; no window.
//   Hold: while win_valid_o & ~win_ready_i, win_* stable and pix_ready_o=0.
//   Handshake without a new window: win_valid_o clears next cycle.
//   Handshake with a new window in the same cycle: win_valid_o stays 1, new data loaded (full rate).
//   Throughput: 1 window/cycle in the steady state of a row; 2 bubble beats at each row start.
//   Windows per frame: exactly (IMG_W-2)*(IMG_H-2).
//   After pixel (IMG_H-1,IMG_W-1) is accepted:
//     - no further pixels accepted;
//     - on the handshake of the final window -> DONE, done_o=1 for 1 cycle, busy_o=0.
//   Reset mid-frame: returns to IDLE next edge; the partial frame is discarded, and no window
//     or done_o is emitted from it.
//   pix_valid_i while not ACTIVE: ignored (pix_ready_o=0).
// TESTING
//   1. IMG_W=4, IMG_H=4, INPUT_CHANNEL=3; p(y,x,c)=y*16+x*4+c; always valid/ready.
//      -> exactly 4 windows in order (0,0),(0,1),(1,0),(1,1).
//      -> first window byte0=0x00, byte26=0x2A; done_o pulses once, 1 cycle after the 4th handshake.
//   2. Same as 1 with win_ready_i low for 5 cycles at the 2nd window.
//      -> win_data_o/row/col held; pix_ready_o=0 during stall; all 4 windows intact, no duplicates.
//   3. Default 32x32 frame, random pix_valid_i/win_ready_i gaps.
//      -> 900 windows; each matches a golden 3x3x3 extraction byte-for-byte.
//   4. Reset asserted 1 cycle after 10th pixel of frame, then new start_i.
//      -> outputs 0 during reset; next frame's first window is (0,0) from new data only.
//   5. start_i pulsed while ACTIVE.
//      -> ignored: counters unaffected, single done_o at frame end.
//   6. Steady row, valid/ready always high.
//      -> win_valid_o high IMG_W-2 consecutive cycles per row; 2-cycle gap at row start.

Source files
------------

// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - raster pixel stream to packed 3x3xC convolution windows
//
// Purpose:
//   Turns a raster-order pixel stream (all channels of one pixel per beat) into
//   one packed 3x3xINPUT_CHANNEL window per output position, stride 1, no padding.
//   Two line buffers hold rows y-1 and y-2. Two column shift registers hold the
//   previous two columns of the current 3-row strip. Windows are emitted with
//   valid/ready backpressure. A new window is loaded on the edge after the
//   pixel that completes it is accepted.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n        synchronous active-low reset
//   start_i      1-cycle pulse, starts a frame (only honoured in IDLE)
//   pix_valid_i  pixel beat valid
//   pix_ready_o  pixel beat accepted on valid & ready
//   pix_data_i   channel c at [c*DATA_W +: DATA_W]
//   win_valid_o  window valid
//   win_ready_i  downstream accepts window on valid & ready
//   win_data_o   sample (c, r, k) at [DATA_W*(c*9 + r*3 + k) +: DATA_W]
//   win_row_o    top-left pixel row of the window
//   win_col_o    top-left pixel col of the window
//   busy_o       frame in progress
//   done_o       1-cycle pulse after the final window handshake

module conv_window_feeder #(
    parameter int IMG_W         = 32,
    parameter int IMG_H         = 32,
    parameter int INPUT_CHANNEL = 3,
    parameter int DATA_W        = 8,
    localparam int WIN_W        = 9 * INPUT_CHANNEL * DATA_W
) (
    input  logic                              clk_i,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic                              pix_valid_i,
    output logic                              pix_ready_o,
    input  logic [INPUT_CHANNEL*DATA_W-1:0]   pix_data_i,
    output logic                              win_valid_o,
    input  logic                              win_ready_i,
    output logic [WIN_W-1:0]                  win_data_o,
    output logic [15:0]                       win_row_o,
    output logic [15:0]                       win_col_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int          PIX_W  = INPUT_CHANNEL * DATA_W;
    localparam int          XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [15:0] X_LAST = 16'(IMG_W - 1);
    localparam logic [15:0] Y_LAST = 16'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       x_q, x_d;
    logic [15:0]       y_q, y_d;
    logic              last_q, last_d;
    logic              win_valid_q, win_valid_d;
    logic [WIN_W-1:0]  win_data_q, win_data_d;
    logic [15:0]       win_row_q, win_row_d;
    logic [15:0]       win_col_q, win_col_d;

    // Line buffers: lb1 holds row y-1, lb2 holds row y-2, indexed by column.
    logic [PIX_W-1:0]  lb1_q [IMG_W];
    logic [PIX_W-1:0]  lb2_q [IMG_W];
    // Column shift registers, index = window row: sr0 = column x-2, sr1 = column x-1.
    logic [PIX_W-1:0]  sr0_q [3];
    logic [PIX_W-1:0]  sr1_q [3];
    logic [PIX_W-1:0]  col_new [3];

    logic              pix_ready;
    logic              pix_fire;
    logic              win_fire;
    logic              load_win;
    logic              at_last_pix;
    logic [XW-1:0]     lb_idx;
    logic [WIN_W-1:0]  win_pack;

    // A pixel may enter only when the output register is free or draining this cycle,
    // so a stalled window is never overwritten.
    assign pix_ready   = (state_q == S_ACTIVE) & ~last_q & (~win_valid_q | win_ready_i);
    assign pix_fire    = pix_valid_i & pix_ready;
    assign win_fire    = win_valid_q & win_ready_i;
    assign lb_idx      = x_q[XW-1:0];
    assign load_win    = pix_fire & (x_q >= 16'd2) & (y_q >= 16'd2);
    assign at_last_pix = (x_q == X_LAST) & (y_q == Y_LAST);

    // Column x of the 3-row strip: oldest row on top, incoming pixel at the bottom.
    always_comb begin
        col_new[0] = lb2_q[lb_idx];
        col_new[1] = lb1_q[lb_idx];
        col_new[2] = pix_data_i;
    end

    // Pack the window for top-left (y-2, x-2) from the two held columns plus the new one.
    always_comb begin
        win_pack = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < INPUT_CHANNEL; c++) begin
                win_pack[DATA_W*(c*9 + r*3 + 0) +: DATA_W] = sr0_q[r][c*DATA_W +: DATA_W];
                win_pack[DATA_W*(c*9 + r*3 + 1) +: DATA_W] = sr1_q[r][c*DATA_W +: DATA_W];
                win_pack[DATA_W*(c*9 + r*3 + 2) +: DATA_W] = col_new[r][c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        last_d      = last_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ACTIVE;
                    x_d     = 16'd0;
                    y_d     = 16'd0;
                    last_d  = 1'b0;
                end
            end

            S_ACTIVE: begin
                if (pix_fire) begin
                    if (x_q == X_LAST) begin
                        x_d = 16'd0;
                        y_d = (y_q == Y_LAST) ? 16'd0 : y_q + 16'd1;
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                    if (at_last_pix) begin
                        last_d = 1'b1;
                    end
                end

                // Loading takes priority over clearing so a handshake plus a new
                // window in the same cycle keeps the stream at full rate.
                if (load_win) begin
                    win_valid_d = 1'b1;
                    win_data_d  = win_pack;
                    win_row_d   = y_q - 16'd2;
                    win_col_d   = x_q - 16'd2;
                end else if (win_fire) begin
                    win_valid_d = 1'b0;
                end

                // Once the last pixel is in, the only pending window is the final one.
                if (last_q & win_fire) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                last_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= 16'd0;
            y_q         <= 16'd0;
            last_q      <= 1'b0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_row_q   <= 16'd0;
            win_col_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            last_q      <= last_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    // Pixel storage carries no reset: stale contents are never used because a
    // window needs two fresh rows and two fresh columns of the current frame.
    always_ff @(posedge clk_i) begin
        if (rst_n && pix_fire) begin
            lb2_q[lb_idx] <= lb1_q[lb_idx];
            lb1_q[lb_idx] <= pix_data_i;
            for (int r = 0; r < 3; r++) begin
                sr0_q[r] <= sr1_q[r];
                sr1_q[r] <= col_new[r];
            end
        end
    end

    assign pix_ready_o = pix_ready;
    assign win_valid_o = win_valid_q;
    assign win_data_o  = win_data_q;
    assign win_row_o   = win_row_q;
    assign win_col_o   = win_col_q;
    assign busy_o      = (state_q == S_ACTIVE);
    assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb/tb_conv_window_feeder.sv - scoreboard bench for conv_window_feeder (4x4 and 32x32 instances)

module tb_conv_window_feeder;

    localparam int BW = 32;
    localparam int BH = 32;
    localparam int WW = 216;

    typedef struct {
        logic [15:0]   row;
        logic [15:0]   col;
        logic [WW-1:0] data;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string name, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    // ---------------- 32x32 instance ----------------
    logic          b_rst_n, b_start, b_pix_valid, b_pix_ready, b_win_valid, b_win_ready, b_busy, b_done;
    logic [23:0]   b_pix_data;
    logic [WW-1:0] b_win_data;
    logic [15:0]   b_win_row, b_win_col;

    conv_window_feeder u_big (
        .clk_i(clk), .rst_n(b_rst_n), .start_i(b_start),
        .pix_valid_i(b_pix_valid), .pix_ready_o(b_pix_ready), .pix_data_i(b_pix_data),
        .win_valid_o(b_win_valid), .win_ready_i(b_win_ready), .win_data_o(b_win_data),
        .win_row_o(b_win_row), .win_col_o(b_win_col), .busy_o(b_busy), .done_o(b_done)
    );

    // ---------------- 4x4 instance ----------------
    logic          s_rst_n, s_start, s_pix_valid, s_pix_ready, s_win_valid, s_win_ready, s_busy, s_done;
    logic [23:0]   s_pix_data;
    logic [WW-1:0] s_win_data;
    logic [15:0]   s_win_row, s_win_col;

    conv_window_feeder #(.IMG_W(4), .IMG_H(4)) u_small (
        .clk_i(clk), .rst_n(s_rst_n), .start_i(s_start),
        .pix_valid_i(s_pix_valid), .pix_ready_o(s_pix_ready), .pix_data_i(s_pix_data),
        .win_valid_o(s_win_valid), .win_ready_i(s_win_ready), .win_data_o(s_win_data),
        .win_row_o(s_win_row), .win_col_o(s_win_col), .busy_o(s_busy), .done_o(s_done)
    );

    // ---------------- reference model ----------------
    logic [23:0] b_mem [BH][BW];
    win_t        b_exp_q[$];
    win_t        s_exp_q[$];

    function automatic logic [WW-1:0] b_ref(input int r0, input int c0);
        logic [WW-1:0] w;
        logic [23:0]   p;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++) begin
                p = b_mem[r0+r][c0+k];
                for (int c = 0; c < 3; c++) w[8*(c*9 + r*3 + k) +: 8] = p[8*c +: 8];
            end
        return w;
    endfunction

    function automatic logic [7:0] s_pix(input int y, input int x, input int c);
        return 8'(y*16 + x*4 + c);
    endfunction

    function automatic logic [WW-1:0] s_ref(input int r0, input int c0);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < 3; c++) w[8*(c*9 + r*3 + k) +: 8] = s_pix(r0+r, c0+k, c);
        return w;
    endfunction

    // ---------------- ready drivers ----------------
    int b_rdy_pct = 100;
    initial begin
        b_win_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            b_win_ready = ($urandom_range(99) < b_rdy_pct);
        end
    end

    bit s_stall_en = 0;
    bit s_stalled  = 0;
    int s_stall_at = -1;
    int s_win_cnt  = 0;
    initial begin
        s_win_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (s_stall_en && !s_stalled && s_win_valid && s_win_cnt == s_stall_at) begin
                s_stalled   = 1;
                s_win_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                s_win_ready = 1'b1;
            end else begin
                s_win_ready = 1'b1;
            end
        end
    end

    // ---------------- monitors ----------------
    int            b_win_cnt = 0, b_done_cnt = 0;
    bit            b_prev_stall = 0;
    logic [15:0]   b_h_row, b_h_col;
    logic [WW-1:0] b_h_data;
    win_t          b_e;
    bit            b_steady_en = 0, b_seen_run = 0;
    int            b_run = 0, b_gap = 0, b_runs_seen = 0;

    always @(negedge clk) begin
        if (!b_rst_n) begin
            b_prev_stall = 0;
        end else begin
            if (b_prev_stall)
                chk(b_win_valid && {b_win_row, b_win_col, b_win_data} == {b_h_row, b_h_col, b_h_data},
                    "b_hold", {b_win_valid, b_win_row, b_win_col, b_win_data}, {1'b1, b_h_row, b_h_col, b_h_data});
            if (b_win_valid && !b_win_ready) chk(!b_pix_ready, "b_pix_ready_in_stall", b_pix_ready, 0);
            b_prev_stall = b_win_valid && !b_win_ready;
            b_h_row = b_win_row; b_h_col = b_win_col; b_h_data = b_win_data;
            if (b_win_valid && b_win_ready) begin
                if (b_exp_q.size() == 0) begin
                    chk(0, "b_unexpected_win", {b_win_row, b_win_col}, 0);
                end else begin
                    b_e = b_exp_q.pop_front();
                    chk({b_win_row, b_win_col, b_win_data} == {b_e.row, b_e.col, b_e.data}, "b_win",
                        {b_win_row, b_win_col, b_win_data}, {b_e.row, b_e.col, b_e.data});
                end
                b_win_cnt++;
            end
            if (b_done) begin
                b_done_cnt++;
                chk(!b_busy && !b_win_valid, "b_done_idle", {b_busy, b_win_valid}, 0);
            end
        end
        if (!b_steady_en) begin
            b_run = 0; b_gap = 0; b_seen_run = 0;
        end else if (b_win_valid) begin
            if (b_seen_run && b_gap > 0) chk(b_gap == 2, "b_row_gap", b_gap, 2);
            b_gap = 0;
            b_run++;
        end else begin
            if (b_run > 0) begin
                chk(b_run == BW-2, "b_row_run", b_run, BW-2);
                b_seen_run = 1;
                b_runs_seen++;
            end
            b_run = 0;
            b_gap++;
        end
    end

    int            s_done_cnt = 0, s_stall_cycles = 0;
    bit            s_prev_stall = 0, s_prev_last_hs = 0;
    logic [15:0]   s_h_row, s_h_col;
    logic [WW-1:0] s_h_data, s_first_win;
    win_t          s_e;

    always @(negedge clk) begin
        if (!s_rst_n) begin
            s_prev_stall = 0; s_prev_last_hs = 0;
        end else begin
            if (s_prev_stall)
                chk(s_win_valid && {s_win_row, s_win_col, s_win_data} == {s_h_row, s_h_col, s_h_data},
                    "s_hold", {s_win_valid, s_win_row, s_win_col, s_win_data}, {1'b1, s_h_row, s_h_col, s_h_data});
            if (s_win_valid && !s_win_ready) begin
                chk(!s_pix_ready, "s_pix_ready_in_stall", s_pix_ready, 0);
                s_stall_cycles++;
            end
            s_prev_stall = s_win_valid && !s_win_ready;
            s_h_row = s_win_row; s_h_col = s_win_col; s_h_data = s_win_data;
            if (s_done || s_prev_last_hs) chk(s_done == s_prev_last_hs, "s_done_timing", s_done, s_prev_last_hs);
            if (s_done) s_done_cnt++;
            s_prev_last_hs = s_win_valid && s_win_ready && s_win_row == 16'd1 && s_win_col == 16'd1;
            if (s_win_valid && s_win_ready) begin
                if (s_win_cnt == 0) s_first_win = s_win_data;
                if (s_exp_q.size() == 0) begin
                    chk(0, "s_unexpected_win", {s_win_row, s_win_col}, 0);
                end else begin
                    s_e = s_exp_q.pop_front();
                    chk({s_win_row, s_win_col, s_win_data} == {s_e.row, s_e.col, s_e.data}, "s_win",
                        {s_win_row, s_win_col, s_win_data}, {s_e.row, s_e.col, s_e.data});
                end
                s_win_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic s_frame();
        int   idx, cyc, w0, d0, y, x;
        win_t e;
        for (int r0 = 0; r0 < 2; r0++)
            for (int c0 = 0; c0 < 2; c0++) begin
                e.row = 16'(r0); e.col = 16'(c0); e.data = s_ref(r0, c0);
                s_exp_q.push_back(e);
            end
        w0 = s_win_cnt; d0 = s_done_cnt;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 16 && cyc < 2000) begin
            @(posedge clk); #1;
            y = idx / 4; x = idx % 4;
            s_pix_valid = 1'b1;
            s_pix_data  = {s_pix(y, x, 2), s_pix(y, x, 1), s_pix(y, x, 0)};
            @(negedge clk);
            if (s_pix_valid && s_pix_ready) idx++;
            cyc++;
        end
        @(posedge clk); #1 s_pix_valid = 1'b0;
        chk(idx == 16, "s_pix_count", idx, 16);
        cyc = 0;
        while (s_done_cnt == d0 && cyc < 200) begin @(posedge clk); cyc++; end
        repeat (3) @(posedge clk);
        chk(s_done_cnt == d0 + 1, "s_done_once", s_done_cnt - d0, 1);
        chk(s_win_cnt - w0 == 4, "s_win_count", s_win_cnt - w0, 4);
        chk(s_exp_q.size() == 0, "s_queue_empty", s_exp_q.size(), 0);
    endtask

    task automatic b_frame(input int vpct, input bit glitch, input int abort_at);
        int   idx, target, cyc, w0, d0;
        bit   gdone;
        win_t e;
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++) b_mem[y][x] = 24'($urandom);
        target = (abort_at >= 0) ? abort_at : BW*BH;
        if (abort_at < 0)
            for (int r0 = 0; r0 < BH-2; r0++)
                for (int c0 = 0; c0 < BW-2; c0++) begin
                    e.row = 16'(r0); e.col = 16'(c0); e.data = b_ref(r0, c0);
                    b_exp_q.push_back(e);
                end
        w0 = b_win_cnt; d0 = b_done_cnt;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        @(negedge clk);
        chk(b_busy, "b_busy_after_start", b_busy, 1);
        idx = 0; cyc = 0; gdone = 0;
        while (idx < target && cyc < 20000) begin
            @(posedge clk); #1;
            b_start = 1'b0;
            if (glitch && !gdone && idx == 300) begin
                b_start = 1'b1;
                gdone   = 1;
            end
            b_pix_valid = ($urandom_range(99) < vpct);
            b_pix_data  = b_mem[idx / BW][idx % BW];
            @(negedge clk);
            if (b_pix_valid && b_pix_ready) idx++;
            cyc++;
        end
        @(posedge clk); #1 b_pix_valid = 1'b0; b_start = 1'b0;
        chk(idx == target, "b_pix_count", idx, target);
        if (abort_at >= 0) begin
            @(posedge clk); #1 b_rst_n = 1'b0; b_pix_valid = 1'b1;
            @(posedge clk);
            repeat (3) begin
                @(negedge clk);
                chk({b_pix_ready, b_win_valid, b_win_data, b_win_row, b_win_col, b_busy, b_done} == '0,
                    "b_reset_outputs", {b_pix_ready, b_win_valid, b_win_data, b_win_row, b_win_col, b_busy, b_done}, 0);
            end
            #1 b_rst_n = 1'b1; b_pix_valid = 1'b0;
            repeat (5) @(posedge clk);
            chk(b_done_cnt == d0 && b_win_cnt == w0, "b_abort_silent", {b_done_cnt - d0, b_win_cnt - w0}, 0);
        end else begin
            cyc = 0;
            while (b_done_cnt == d0 && cyc < 5000) begin @(posedge clk); cyc++; end
            repeat (3) @(posedge clk);
            chk(b_done_cnt == d0 + 1, "b_done_once", b_done_cnt - d0, 1);
            chk(b_win_cnt - w0 == (BW-2)*(BH-2), "b_win_count", b_win_cnt - w0, (BW-2)*(BH-2));
            chk(b_exp_q.size() == 0, "b_queue_empty", b_exp_q.size(), 0);
        end
    endtask

    initial begin
        b_rst_n = 1'b0; b_start = 1'b0; b_pix_valid = 1'b1; b_pix_data = '0;
        s_rst_n = 1'b0; s_start = 1'b0; s_pix_valid = 1'b1; s_pix_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({b_pix_ready, b_win_valid, b_win_data, b_win_row, b_win_col, b_busy, b_done} == '0, "b_reset_state",
            {b_pix_ready, b_win_valid, b_win_data, b_win_row, b_win_col, b_busy, b_done}, 0);
        chk({s_pix_ready, s_win_valid, s_win_data, s_win_row, s_win_col, s_busy, s_done} == '0, "s_reset_state",
            {s_pix_ready, s_win_valid, s_win_data, s_win_row, s_win_col, s_busy, s_done}, 0);
        b_rst_n = 1'b1; s_rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(!b_pix_ready && !b_busy && !b_win_valid, "b_idle_ignores_pix", {b_pix_ready, b_busy, b_win_valid}, 0);
        chk(!s_pix_ready && !s_busy && !s_win_valid, "s_idle_ignores_pix", {s_pix_ready, s_busy, s_win_valid}, 0);
        b_pix_valid = 1'b0; s_pix_valid = 1'b0;

        // 4x4 frame, always valid/ready
        s_frame();
        chk(s_first_win[7:0] == 8'h00, "s_first_byte0", s_first_win[7:0], 8'h00);
        chk(s_first_win[215:208] == 8'h2A, "s_first_byte26", s_first_win[215:208], 8'h2A);

        // 4x4 frame with a 5-cycle stall on the second window
        s_stall_at = s_win_cnt + 1;
        s_stall_en = 1;
        s_frame();
        chk(s_stall_cycles == 5, "s_stall_cycles", s_stall_cycles, 5);

        // 32x32 steady frame: row runs of IMG_W-2 windows with 2-cycle gaps
        b_rdy_pct   = 100;
        b_steady_en = 1;
        b_frame(100, 0, -1);
        b_steady_en = 0;
        chk(b_runs_seen == BH-2, "b_runs_seen", b_runs_seen, BH-2);

        // 32x32 random gaps with a start pulse mid-frame
        b_rdy_pct = 70;
        b_frame(75, 1, -1);

        // reset after the 10th pixel, then a fresh frame
        b_frame(80, 0, 10);
        b_frame(70, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
